// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, a single held
// instruction toward execute, redirect handling and a sticky misalignment fault.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_instr_count;
  logic        r_fault;
  logic        r_active;
  logic        w_load;
  logic        w_redir_ok;
  logic        w_redir_bad;
  logic        w_req_hs;
  logic        w_fire;

  assign w_redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // r_active keeps the request low until the first edge after reset release.
  assign imem_req_valid = r_active && (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;
  assign instr_valid    = (r_state == S_HOLD);
  assign w_fire         = instr_valid && instr_ready;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign fault          = r_fault;
  assign instr_count    = r_instr_count;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    if ((r_state != S_HALT) && w_redir_bad) begin
      w_state_nxt = S_HALT;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_redir_ok) begin
            w_pc_nxt = redirect_pc;
            if (w_req_hs) w_state_nxt = S_DRAIN;
          end else if (w_req_hs) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redir_ok) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
          end else if (imem_rsp_valid) begin
            w_load      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_redir_ok) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_REQ;
          end else if (instr_ready) begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_REQ;
          end
        end
        S_DRAIN: begin
          if (w_redir_ok) w_pc_nxt = redirect_pc;
          if (imem_rsp_valid) w_state_nxt = S_REQ;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_active <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_active <= 1'b1;
      if (w_state_nxt == S_HALT) r_fault <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_load) begin
      r_instr    <= imem_rsp_data;
      r_instr_pc <= r_pc;
    end
  end

  // Every handshake counts, including one coinciding with a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (w_fire) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset (word aligned).
REQ-002 clk  input  1  single clock for all state; rising edge active.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  32  byte address of request, equal to current PC.
REQ-007 imem_rsp_valid  input  1  memory returns one instruction word this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 instr_valid  output  1  instruction available to execute stage.
REQ-010 instr_ready  input  1  execute stage consumes instruction this cycle.
REQ-011 instr  output  32  held instruction word.
REQ-012 instr_pc  output  32  PC of held instruction.
REQ-013 redirect_valid  input  1  control-flow change (jal/branch) from execute.
REQ-014 redirect_pc  input  32  new PC target.
REQ-015 fault  output  1  sticky misaligned-redirect flag.
REQ-016 instr_count  output  32  number of instr_valid&&instr_ready handshakes.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, DRAIN, HALT; one request outstanding at most.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT next cycle.
REQ-019 WAIT: on imem_rsp_valid, instr<=imem_rsp_data, instr_pc<=pc, -> HOLD; instr_valid=1 starting the following cycle.
REQ-020 HOLD: instr_valid=1, instr/instr_pc stable; on instr_ready, pc<=pc+4 (mod 2^32), instr_count+1, -> REQ.
REQ-021 Minimum fetch latency SHALL be 2 cycles from request handshake to instr_valid with zero-wait memory (req accepted cycle N, rsp cycle N+1, instr_valid cycle N+2).
REQ-022 imem_req_valid, once high, SHALL stay high with stable address until handshake, except when a redirect changes the address (REQ-024).
REQ-023 Redirect (aligned) SHALL have priority over every other event in all non-HALT states and SHALL load pc<=redirect_pc.
REQ-024 Redirect in REQ without handshake: stay REQ, address updated next cycle; with handshake same cycle: -> DRAIN.
REQ-025 Redirect in WAIT without rsp_valid: -> DRAIN; with rsp_valid same cycle: response discarded, -> REQ.
REQ-026 Redirect in HOLD: instr_valid drops next cycle, -> REQ; if instr_ready same cycle, handshake counts in instr_count but pc<=redirect_pc (not pc+4).
REQ-027 DRAIN: imem_req_valid=0, instr_valid=0; next imem_rsp_valid discarded, -> REQ; further redirects update pc only.
REQ-028 Redirect with redirect_pc[1:0]!=0 SHALL set fault=1 and -> HALT from any state; pc unchanged.
REQ-029 HALT: imem_req_valid=0, instr_valid=0, all inputs ignored, exit only by reset.
REQ-030 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 imem_rsp_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-032 While reset=0: state=REQ, pc=RESET_PC, instr=0, instr_pc=0, instr_count=0, fault=0, instr_valid=0.
REQ-033 imem_req_valid SHALL be 0 while reset=0 and 1 from the first clk edge after reset releases.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding request; no response after release is accepted until a new request handshake.

Verification
REQ-035 Zero-wait memory, instr_ready=1, words at 0,4,8 -> addresses 0,4,8 issued; instr_pc 0,4,8; instr_count=3.
REQ-036 imem_req_ready low 3 cycles, rsp delayed 2 cycles, instr_ready low 2 cycles -> addr held stable, instr held stable, no duplicate/lost instruction.
REQ-037 Redirect to 0x100 in WAIT -> DRAIN, stale rsp dropped, next request addr 0x100, instr_pc 0x100.
REQ-038 Redirect to 0x40 concurrent with instr_ready in HOLD at pc 0x8 -> instr_count+1, next addr 0x40 (not 0xC).
REQ-039 Redirect to 0x102 -> fault=1, HALT, no further requests; reset low then high -> fault=0, addr RESET_PC.
REQ-040 PC 0xFFFF_FFFC consumed -> next addr 0x0000_0000; instr_count preloaded near wrap rolls to 0.
